// File: rtl/mantissa_align.sv
// mantissa_align: orders the two operands of a floating-point add as
// large/small and right-aligns the small mantissa into a
// guard/round/sticky-extended word. Two valid-qualified pipeline stages;
// data registers hold their contents while their stage is idle.
module mantissa_align #(
  parameter int MANT_W = 24,
  parameter int EXT_W  = MANT_W + 3
) (
  input  logic              clk,
  input  logic              rstn,            // synchronous, active-high
  input  logic              valid_in,
  input  logic              swap,
  input  logic [7:0]        different,
  input  logic [7:0]        larger_exponent,
  input  logic              signA,
  input  logic              signB,
  input  logic [MANT_W-1:0] mantissaA,
  input  logic [MANT_W-1:0] mantissaB,
  output logic              valid_out,
  output logic [7:0]        exponent_out,
  output logic              sign_large,
  output logic              sign_small,
  output logic [EXT_W-1:0]  mantissa_large,
  output logic [EXT_W-1:0]  mantissa_small
);

  // Guard/round/sticky bits appended below the mantissa.
  localparam int GRS_W   = EXT_W - MANT_W;
  // Shift register width must hold the clamp value EXT_W itself.
  localparam int SHIFT_W = $clog2(EXT_W + 1);

  localparam logic [7:0]         EXT_W_B = 8'(EXT_W);
  localparam logic [SHIFT_W-1:0] EXT_W_S = SHIFT_W'(EXT_W);

  // ---------------------------------------------------------------------
  // Stage 1 state
  // ---------------------------------------------------------------------
  logic               s1_valid;
  logic [7:0]         s1_exp;
  logic               s1_sign_l;
  logic               s1_sign_s;
  logic [MANT_W-1:0]  s1_mant_l;
  logic [MANT_W-1:0]  s1_mant_s;
  logic [SHIFT_W-1:0] s1_shift;

  // Stage 1 combinational selects
  logic               sel_sign_l;
  logic               sel_sign_s;
  logic [MANT_W-1:0]  sel_mant_l;
  logic [MANT_W-1:0]  sel_mant_s;
  logic [SHIFT_W-1:0] clamp_shift;

  // Stage 2 combinational alignment
  logic [EXT_W-1:0]   ext_small;
  logic [EXT_W-1:0]   lost_mask;
  logic [EXT_W-1:0]   aligned_small;
  logic [EXT_W-1:0]   ext_large;

  // Operand ordering and shift clamp. Equal exponents leave A as large,
  // since the upstream stage only raises swap when B's exponent is bigger.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // branch, so no path leaves a value unassigned and no latch is inferred.
    sel_sign_l  = signA;
    sel_sign_s  = signB;
    sel_mant_l  = mantissaA;
    sel_mant_s  = mantissaB;
    clamp_shift = different[SHIFT_W-1:0];
    if (swap) begin
      sel_sign_l = signB;
      sel_sign_s = signA;
      sel_mant_l = mantissaB;
      sel_mant_s = mantissaA;
    end
    // Any shift of EXT_W or more moves every bit into sticky, so larger
    // differences collapse onto EXT_W and the stage-1 register stays narrow.
    if (different >= EXT_W_B) begin
      clamp_shift = EXT_W_S;
    end
  end

  // Stage 1 register: valid always follows valid_in, data loads only on valid.
  always_ff @(posedge clk) begin
    // NOTE: data registers are cleared on reset along with the valids, so
    // the outputs read as zero right after reset instead of stale values.
    if (rstn) begin
      // NOTE: sequential state uses non-blocking assignment so every
      // register samples pre-edge values regardless of statement order.
      s1_valid  <= 1'b0;
      s1_exp    <= '0;
      s1_sign_l <= 1'b0;
      s1_sign_s <= 1'b0;
      s1_mant_l <= '0;
      s1_mant_s <= '0;
      s1_shift  <= '0;
    end else begin
      s1_valid <= valid_in;
      if (valid_in) begin
        s1_exp    <= larger_exponent;
        s1_sign_l <= sel_sign_l;
        s1_sign_s <= sel_sign_s;
        s1_mant_l <= sel_mant_l;
        s1_mant_s <= sel_mant_s;
        s1_shift  <= clamp_shift;
      end
    end
  end

  // Right-shift the extended small mantissa and fold the lost bits into
  // the sticky LSB; a clamped shift leaves only the sticky bit.
  always_comb begin
    ext_small     = {s1_mant_s, {GRS_W{1'b0}}};
    ext_large     = {s1_mant_l, {GRS_W{1'b0}}};
    // Ones in exactly the bit positions that fall off the bottom.
    lost_mask     = ~({EXT_W{1'b1}} << s1_shift);
    aligned_small = '0;
    if (s1_shift >= EXT_W_S) begin
      aligned_small = {{(EXT_W-1){1'b0}}, |s1_mant_s};
    end else begin
      aligned_small = (ext_small >> s1_shift)
                    | {{(EXT_W-1){1'b0}}, |(ext_small & lost_mask)};
    end
  end

  // Stage 2 register: outputs update only while stage 1 holds a transfer.
  always_ff @(posedge clk) begin
    if (rstn) begin
      valid_out      <= 1'b0;
      exponent_out   <= '0;
      sign_large     <= 1'b0;
      sign_small     <= 1'b0;
      mantissa_large <= '0;
      mantissa_small <= '0;
    end else begin
      valid_out <= s1_valid;
      if (s1_valid) begin
        exponent_out   <= s1_exp;
        sign_large     <= s1_sign_l;
        sign_small     <= s1_sign_s;
        mantissa_large <= ext_large;
        mantissa_small <= aligned_small;
      end
    end
  end

endmodule

// File: tb/tb_mantissa_align.sv
// Self-checking bench for mantissa_align: directed test-plan vectors with
// literal expectations, then randomized traffic checked against an
// arithmetic reference model (quotient/remainder alignment).
module tb_mantissa_align;

  localparam int MW = 24;
  localparam int EW = MW + 3;

  logic          clk = 1'b0;
  logic          rstn;
  logic          valid_in;
  logic          swap;
  logic [7:0]    different;
  logic [7:0]    larger_exponent;
  logic          signA, signB;
  logic [MW-1:0] mantissaA, mantissaB;
  logic          valid_out;
  logic [7:0]    exponent_out;
  logic          sign_large, sign_small;
  logic [EW-1:0] mantissa_large, mantissa_small;

  mantissa_align #(.MANT_W(MW), .EXT_W(EW)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .valid_in        (valid_in),
    .swap            (swap),
    .different       (different),
    .larger_exponent (larger_exponent),
    .signA           (signA),
    .signB           (signB),
    .mantissaA       (mantissaA),
    .mantissaB       (mantissaB),
    .valid_out       (valid_out),
    .exponent_out    (exponent_out),
    .sign_large      (sign_large),
    .sign_small      (sign_small),
    .mantissa_large  (mantissa_large),
    .mantissa_small  (mantissa_small)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            v;
    logic [7:0]    e;
    logic          sl;
    logic          ss;
    logic [EW-1:0] ml;
    logic [EW-1:0] ms;
  } res_t;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  res_t           hist[$];   // transfer accepted at the previous edge
  res_t           held;      // expected output register contents
  bit             exp_v;
  logic [15:0]    vo_hist = '0;

  function automatic res_t empty_res();
    res_t r;
    r.v = 1'b0; r.e = '0; r.sl = 1'b0; r.ss = 1'b0; r.ml = '0; r.ms = '0;
    return r;
  endfunction

  // Reference: alignment as integer division by 2**d, sticky = remainder != 0.
  function automatic res_t model(input logic sw, input logic [7:0] d,
                                 input logic [7:0] e, input logic sa,
                                 input logic sb, input logic [MW-1:0] ma,
                                 input logic [MW-1:0] mb);
    res_t r;
    logic [MW-1:0]   lg, sm;
    longint unsigned ext, dv, q, rem;
    lg  = sw ? mb : ma;
    sm  = sw ? ma : mb;
    ext = longint'(sm) * 8;
    if (d >= 8'(EW)) begin
      q = 0; rem = ext;
    end else begin
      dv = 64'd1 << d; q = ext / dv; rem = ext % dv;
    end
    r.v  = 1'b1;
    r.e  = e;
    r.sl = sw ? sb : sa;
    r.ss = sw ? sa : sb;
    r.ml = {lg, 3'b000};
    r.ms = EW'(q) | EW'(rem != 0);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic sw, input logic [7:0] d,
                        input logic [7:0] e, input logic sa, input logic sb,
                        input logic [MW-1:0] ma, input logic [MW-1:0] mb);
    valid_in = v; swap = sw; different = d; larger_exponent = e;
    signA = sa; signB = sb; mantissaA = ma; mantissaB = mb;
  endtask

  // One clock: advance the model, then compare every output #1 after the edge.
  task automatic tick();
    res_t cur, r;
    cur   = model(swap, different, larger_exponent, signA, signB,
                  mantissaA, mantissaB);
    cur.v = valid_in && !rstn;
    @(posedge clk);
    if (rstn) begin
      hist.delete();
      hist.push_back(empty_res());
      held  = empty_res();
      exp_v = 1'b0;
    end else begin
      r = hist.pop_front();
      hist.push_back(cur);
      exp_v = r.v;
      if (r.v) held = r;
    end
    #1;
    vo_hist = {vo_hist[14:0], valid_out};
    check("valid_out",      32'(valid_out),      32'(exp_v));
    check("exponent_out",   32'(exponent_out),   32'(held.e));
    check("sign_large",     32'(sign_large),     32'(held.sl));
    check("sign_small",     32'(sign_small),     32'(held.ss));
    check("mantissa_large", 32'(mantissa_large), 32'(held.ml));
    check("mantissa_small", 32'(mantissa_small), 32'(held.ms));
  endtask

  // Apply one transfer, then one idle cycle so its result is on the outputs.
  task automatic xfer(input logic sw, input logic [7:0] d, input logic [7:0] e,
                      input logic sa, input logic sb,
                      input logic [MW-1:0] ma, input logic [MW-1:0] mb);
    set_in(1'b1, sw, d, e, sa, sb, ma, mb);
    tick();
    valid_in = 1'b0;
    tick();
  endtask

  res_t r4;

  initial begin
    hist.push_back(empty_res());
    held = empty_res();

    // Reset with junk on valid_in: it must be ignored.
    rstn = 1'b1;
    set_in(1'b1, 1'b1, 8'd5, 8'h7F, 1'b1, 1'b1, 24'hFFFFFF, 24'hABCDEF);
    tick();
    tick();
    check("rst_valid_out", 32'(valid_out), 32'd0);
    check("rst_mant_small", 32'(mantissa_small), 32'd0);
    rstn = 1'b0;
    valid_in = 1'b0;
    tick();
    check("rst_release_idle", 32'(valid_out), 32'd0);

    // Shift 1, no swap.
    xfer(1'b0, 8'd1, 8'h80, 1'b0, 1'b0, 24'h800000, 24'hC00000);
    check("tp_shift1_large", 32'(mantissa_large), 32'h4000000);
    check("tp_shift1_small", 32'(mantissa_small), 32'h3000000);
    check("tp_shift1_exp",   32'(exponent_out),   32'h80);

    // Sticky clear / set.
    xfer(1'b0, 8'd3, 8'h90, 1'b0, 1'b0, 24'h800000, 24'h800001);
    check("tp_sticky_d3", 32'(mantissa_small), 32'h0800001);
    xfer(1'b0, 8'd4, 8'h90, 1'b0, 1'b0, 24'h800000, 24'h800001);
    check("tp_sticky_d4", 32'(mantissa_small), 32'h0400001);

    // Clamp and just-below-clamp.
    xfer(1'b0, 8'd30, 8'hA0, 1'b0, 1'b0, 24'h800000, 24'h800001);
    check("tp_clamp_d30", 32'(mantissa_small), 32'h0000001);
    xfer(1'b0, 8'd26, 8'hA0, 1'b0, 1'b0, 24'h800000, 24'h800000);
    check("tp_clamp_d26", 32'(mantissa_small), 32'h0000001);

    // Swap.
    xfer(1'b1, 8'd2, 8'h85, 1'b1, 1'b0, 24'hC00000, 24'h800000);
    check("tp_swap_sign_large", 32'(sign_large),     32'd0);
    check("tp_swap_sign_small", 32'(sign_small),     32'd1);
    check("tp_swap_large",      32'(mantissa_large), 32'h4000000);
    check("tp_swap_small",      32'(mantissa_small), 32'h1800000);

    // Equal exponents: A stays large even with the smaller mantissa.
    xfer(1'b0, 8'd0, 8'h70, 1'b0, 1'b1, 24'h800000, 24'hFFFFFF);
    check("tp_equal_large", 32'(mantissa_large), 32'h4000000);
    check("tp_equal_small", 32'(mantissa_small), 32'h7FFFFF8);

    // Streaming: 4 back-to-back, 2-cycle gap, 1 more.
    set_in(1'b1, 1'b0, 8'd1, 8'h11, 1'b0, 1'b1, 24'h812345, 24'hF0000F); tick();
    set_in(1'b1, 1'b1, 8'd7, 8'h22, 1'b1, 1'b0, 24'h9ABCDE, 24'hC00001); tick();
    set_in(1'b1, 1'b0, 8'd12, 8'h33, 1'b1, 1'b1, 24'hA00000, 24'hBFFFFF); tick();
    set_in(1'b1, 1'b1, 8'd5, 8'h44, 1'b0, 1'b1, 24'h80001F, 24'hE00000);
    r4 = model(1'b1, 8'd5, 8'h44, 1'b0, 1'b1, 24'h80001F, 24'hE00000);
    tick();
    valid_in = 1'b0; tick();
    tick();
    check("stream_hold_gap1", 32'(mantissa_small), 32'(r4.ms));
    set_in(1'b1, 1'b0, 8'd2, 8'h55, 1'b0, 1'b0, 24'hFFFFFF, 24'h800003); tick();
    check("stream_hold_gap2", 32'(mantissa_small), 32'(r4.ms));
    check("stream_hold_exp",  32'(exponent_out),   32'h44);
    valid_in = 1'b0; tick();
    tick();
    check("stream_valid_pattern", 32'(vo_hist[7:1]), 32'b1111001);

    // Reset mid-pipe: T1 in stage 1, T2 presented during reset.
    set_in(1'b1, 1'b0, 8'd3, 8'h66, 1'b1, 1'b0, 24'hC12345, 24'h812345); tick();
    rstn = 1'b1;
    set_in(1'b1, 1'b1, 8'd4, 8'h77, 1'b0, 1'b1, 24'hD00000, 24'h900000); tick();
    check("midrst_valid", 32'(valid_out),      32'd0);
    check("midrst_large", 32'(mantissa_large), 32'd0);
    check("midrst_exp",   32'(exponent_out),   32'd0);
    rstn = 1'b0;
    valid_in = 1'b0;
    tick();
    check("midrst_t1_dropped", 32'(valid_out), 32'd0);
    tick();
    check("midrst_t2_dropped", 32'(valid_out), 32'd0);
    xfer(1'b0, 8'd1, 8'h81, 1'b0, 1'b0, 24'h800000, 24'hC00000);
    check("midrst_new_valid", 32'(valid_out),      32'd1);
    check("midrst_new_small", 32'(mantissa_small), 32'h3000000);

    // Randomized traffic, including occasional resets and huge differences.
    for (int i = 0; i < 400; i++) begin
      logic [7:0] d;
      rstn = ($urandom_range(0, 63) == 0);
      d = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 30));
      set_in($urandom_range(0, 3) != 0, 1'($urandom), d, 8'($urandom),
             1'($urandom), 1'($urandom),
             {1'b1, 23'($urandom)},
             ($urandom_range(0, 3) == 0) ? MW'($urandom_range(0, 255))
                                         : {1'b1, 23'($urandom)});
      tick();
    end
    rstn = 1'b0;
    valid_in = 1'b0;
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
